// File: rtl/wb_delta_fetcher.sv
// Walks a WB SRAM region holding a packed, delta-encoded unique-weight stream and
// emits absolute (weight, repetition) pairs on a valid/ready stream.
module wb_delta_fetcher #(
    parameter int WORD_W        = 64,
    parameter int BIN_LEN       = 8,
    parameter int MAX_DELTA_LEN = 8,
    parameter int MAX_NUM_LEN   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [31:0]            base_addr,
    input  logic [15:0]            entry_count,
    input  logic [3:0]             delta_len,
    input  logic [3:0]             num_len,
    input  logic [BIN_LEN-1:0]     base_weight,
    output logic                   sram_read,
    output logic [31:0]            sram_address,
    input  logic                   sram_ready,
    input  logic [WORD_W-1:0]      sram_in,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [BIN_LEN-1:0]     w_value,
    output logic [MAX_NUM_LEN-1:0] w_rep,
    output logic                   w_last,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);
    localparam int BUF_W = 2 * WORD_W;
    localparam int OCC_W = $clog2(BUF_W + 1);
    localparam logic [OCC_W-1:0] WORD_OCC = OCC_W'(WORD_W);
    localparam logic [4:0] MAX_DL = 5'(MAX_DELTA_LEN);
    localparam logic [4:0] MAX_NL = 5'(MAX_NUM_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, DONE} state_e;

    state_e                 state_q, state_d;
    logic [3:0]             dl_q, dl_d;
    logic [3:0]             nl_q, nl_d;
    logic [OCC_W-1:0]       ent_len_q, ent_len_d;
    logic [15:0]            count_q, count_d;
    logic [31:0]            base_q, base_d;
    logic [31:0]            total_q, total_d;
    logic [31:0]            words_q, words_d;
    logic [15:0]            ent_cnt_q, ent_cnt_d;
    logic [BUF_W-1:0]       buf_q, buf_d;
    logic [OCC_W-1:0]       occ_q, occ_d;
    logic [BIN_LEN-1:0]     acc_q, acc_d;
    logic                   sram_read_q, sram_read_d;
    logic [31:0]            sram_address_q, sram_address_d;
    logic                   w_valid_q, w_valid_d;
    logic [BIN_LEN-1:0]     w_value_q, w_value_d;
    logic [MAX_NUM_LEN-1:0] w_rep_q, w_rep_d;
    logic                   w_last_q, w_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;

    logic [MAX_DELTA_LEN-1:0] dmask, delta_f;
    logic [MAX_NUM_LEN-1:0]   nmask, rep_f;
    logic [OCC_W-1:0]         new_len;
    logic                     running, accept, take, fill, cfg_bad;

    always_comb begin
        state_d        = state_q;
        dl_d           = dl_q;
        nl_d           = nl_q;
        ent_len_d      = ent_len_q;
        count_d        = count_q;
        base_d         = base_q;
        total_d        = total_q;
        words_d        = words_q;
        ent_cnt_d      = ent_cnt_q;
        buf_d          = buf_q;
        occ_d          = occ_q;
        acc_d          = acc_q;
        sram_read_d    = sram_read_q;
        sram_address_d = sram_address_q;
        w_valid_d      = w_valid_q;
        w_value_d      = w_value_q;
        w_rep_d        = w_rep_q;
        w_last_d       = w_last_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        cfg_err_d      = 1'b0;

        dmask   = ~({MAX_DELTA_LEN{1'b1}} << dl_q);
        nmask   = ~({MAX_NUM_LEN{1'b1}} << nl_q);
        delta_f = MAX_DELTA_LEN'(buf_q) & dmask;
        rep_f   = MAX_NUM_LEN'(buf_q >> dl_q) & nmask;
        running = (state_q == FETCH) || (state_q == DECODE);
        accept  = w_valid_q && w_ready;
        take    = running && (occ_q >= ent_len_q) && (ent_cnt_q < count_q) &&
                  (!w_valid_q || w_ready);
        fill    = (state_q == FETCH) && sram_read_q && sram_ready;
        new_len = OCC_W'(delta_len) + OCC_W'(num_len);
        cfg_bad = (delta_len == 4'd0) || ({1'b0, delta_len} > MAX_DL) ||
                  (num_len == 4'd0) || ({1'b0, num_len} > MAX_NL);

        case (state_q)
            IDLE: begin
                if (start) begin
                    dl_d      = delta_len;
                    nl_d      = num_len;
                    ent_len_d = new_len;
                    count_d   = entry_count;
                    base_d    = base_addr;
                    total_d   = (32'(entry_count) * 32'(new_len) + 32'(WORD_W - 1)) / 32'(WORD_W);
                    words_d   = '0;
                    ent_cnt_d = '0;
                    buf_d     = '0;
                    occ_d     = '0;
                    acc_d     = base_weight;
                    if (cfg_bad) begin
                        state_d   = DONE;
                        done_d    = 1'b1;
                        cfg_err_d = 1'b1;
                    end else if (entry_count == 16'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d        = FETCH;
                        busy_d         = 1'b1;
                        sram_read_d    = 1'b1;
                        sram_address_d = base_addr;
                    end
                end
            end
            FETCH, DECODE: begin
                if (accept) begin
                    w_valid_d = 1'b0;
                end
                if (take) begin
                    acc_d     = acc_q + BIN_LEN'(delta_f);
                    w_value_d = acc_d;
                    w_rep_d   = rep_f;
                    w_last_d  = (ent_cnt_q == count_q - 16'd1);
                    w_valid_d = 1'b1;
                    ent_cnt_d = ent_cnt_q + 16'd1;
                    buf_d     = buf_q >> ent_len_q;
                    occ_d     = occ_q - ent_len_q;
                end
                // the fresh word lands above whatever survives this cycle's consume
                if (fill) begin
                    buf_d   = buf_d | (BUF_W'(sram_in) << occ_d);
                    occ_d   = occ_d + WORD_OCC;
                    words_d = words_q + 32'd1;
                end
                if (state_q == FETCH) begin
                    if (!(sram_read_q && !sram_ready)) begin
                        sram_read_d = (words_d < total_q) && (occ_d <= WORD_OCC);
                        if (sram_read_d) begin
                            sram_address_d = base_q + words_d;
                        end
                    end
                    if (words_d == total_q) begin
                        state_d = DECODE;
                    end
                end
                if (accept && w_last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            dl_q           <= '0;
            nl_q           <= '0;
            ent_len_q      <= '0;
            count_q        <= '0;
            base_q         <= '0;
            total_q        <= '0;
            words_q        <= '0;
            ent_cnt_q      <= '0;
            buf_q          <= '0;
            occ_q          <= '0;
            acc_q          <= '0;
            sram_read_q    <= 1'b0;
            sram_address_q <= '0;
            w_valid_q      <= 1'b0;
            w_value_q      <= '0;
            w_rep_q        <= '0;
            w_last_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            dl_q           <= dl_d;
            nl_q           <= nl_d;
            ent_len_q      <= ent_len_d;
            count_q        <= count_d;
            base_q         <= base_d;
            total_q        <= total_d;
            words_q        <= words_d;
            ent_cnt_q      <= ent_cnt_d;
            buf_q          <= buf_d;
            occ_q          <= occ_d;
            acc_q          <= acc_d;
            sram_read_q    <= sram_read_d;
            sram_address_q <= sram_address_d;
            w_valid_q      <= w_valid_d;
            w_value_q      <= w_value_d;
            w_rep_q        <= w_rep_d;
            w_last_q       <= w_last_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cfg_err_q      <= cfg_err_d;
        end
    end

    assign sram_read    = sram_read_q;
    assign sram_address = sram_address_q;
    assign w_valid      = w_valid_q;
    assign w_value      = w_value_q;
    assign w_rep        = w_rep_q;
    assign w_last       = w_last_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_wb_delta_fetcher.sv
// Directed bench for wb_delta_fetcher: an SRAM responder with programmable wait
// states, a pair collector, and hand-computed expected pairs per job.
module tb_wb_delta_fetcher;
    localparam int WORD_W        = 64;
    localparam int BIN_LEN       = 8;
    localparam int MAX_DELTA_LEN = 8;
    localparam int MAX_NUM_LEN   = 8;

    logic                   clock       = 1'b0;
    logic                   reset       = 1'b0;
    logic                   start       = 1'b0;
    logic [31:0]            base_addr   = '0;
    logic [15:0]            entry_count = '0;
    logic [3:0]             delta_len   = '0;
    logic [3:0]             num_len     = '0;
    logic [BIN_LEN-1:0]     base_weight = '0;
    logic                   sram_read;
    logic [31:0]            sram_address;
    logic                   sram_ready  = 1'b0;
    logic [WORD_W-1:0]      sram_in     = '0;
    logic                   w_valid;
    logic                   w_ready     = 1'b1;
    logic [BIN_LEN-1:0]     w_value;
    logic [MAX_NUM_LEN-1:0] w_rep;
    logic                   w_last;
    logic                   busy;
    logic                   done;
    logic                   cfg_err;

    wb_delta_fetcher #(
        .WORD_W(WORD_W),
        .BIN_LEN(BIN_LEN),
        .MAX_DELTA_LEN(MAX_DELTA_LEN),
        .MAX_NUM_LEN(MAX_NUM_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .entry_count(entry_count),
        .delta_len(delta_len),
        .num_len(num_len),
        .base_weight(base_weight),
        .sram_read(sram_read),
        .sram_address(sram_address),
        .sram_ready(sram_ready),
        .sram_in(sram_in),
        .w_valid(w_valid),
        .w_ready(w_ready),
        .w_value(w_value),
        .w_rep(w_rep),
        .w_last(w_last),
        .busy(busy),
        .done(done),
        .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SRAM responder: memory indexed relative to the job base address
    logic [WORD_W-1:0] mem [4];
    logic [31:0]       cur_base    = '0;
    int                wait_states = 0;
    int                wcnt        = 0;
    logic              pending     = 1'b0;
    logic [31:0]       pend_addr   = '0;
    int                hold_cnt    = 0;
    int                stab_err    = 0;
    logic [31:0]       rd_log [$];
    logic [31:0]       idx;

    always @(negedge clock) begin
        if (!reset) begin
            sram_ready = 1'b0;
            pending    = 1'b0;
            wcnt       = 0;
        end else begin
            if (sram_ready) begin
                sram_ready = 1'b0;
                pending    = 1'b0;
            end
            if (pending) begin
                hold_cnt++;
                if (!sram_read || sram_address !== pend_addr) stab_err++;
            end
            if (sram_read) begin
                if (!pending) begin
                    pending   = 1'b1;
                    pend_addr = sram_address;
                    wcnt      = 0;
                end
                if (wcnt >= wait_states) begin
                    idx        = sram_address - cur_base;
                    sram_in    = mem[idx[1:0]];
                    sram_ready = 1'b1;
                    rd_log.push_back(sram_address);
                end else begin
                    wcnt++;
                end
            end
        end
    end

    logic [BIN_LEN-1:0]     got_v [$];
    logic [MAX_NUM_LEN-1:0] got_r [$];
    logic                   got_l [$];
    int                     done_cnt = 0;

    always @(negedge clock) begin
        if (w_valid && w_ready) begin
            got_v.push_back(w_value);
            got_r.push_back(w_rep);
            got_l.push_back(w_last);
        end
        if (done) done_cnt++;
    end

    logic [255:0] stream;
    int g0, r0, d0, h0, s0;

    task automatic put_entry(input int k, input int dl, input int nl, input int delta, input int rep);
        int pos;
        pos = k * (dl + nl);
        for (int b = 0; b < dl; b++) stream[pos + b] = delta[b];
        for (int b = 0; b < nl; b++) stream[pos + dl + b] = rep[b];
    endtask

    task automatic load_mem();
        for (int k = 0; k < 4; k++) mem[k] = stream[k * WORD_W +: WORD_W];
    endtask

    task automatic snap();
        g0 = got_v.size();
        r0 = rd_log.size();
        d0 = done_cnt;
        h0 = hold_cnt;
        s0 = stab_err;
    endtask

    task automatic start_job(input logic [31:0] base, input logic [15:0] cnt, input logic [3:0] dl,
                             input logic [3:0] nl, input logic [7:0] bw, input int ws);
        @(posedge clock); #1;
        cur_base    = base;
        wait_states = ws;
        base_addr   = base;
        entry_count = cnt;
        delta_len   = dl;
        num_len     = nl;
        base_weight = bw;
        start       = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_at_done"}, busy, 0);
        @(posedge clock); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic check_pair(input string tag, input int k, input int ev, input int er, input int el);
        if (g0 + k < got_v.size()) begin
            check({tag, "_val"}, got_v[g0 + k], ev);
            check({tag, "_rep"}, got_r[g0 + k], er);
            check({tag, "_last"}, got_l[g0 + k], el);
        end else begin
            check({tag, "_present"}, got_v.size() - g0, k + 1);
        end
    endtask

    task automatic check_rd(input string tag, input int k, input logic [31:0] exp);
        if (r0 + k < rd_log.size()) check(tag, rd_log[r0 + k], exp);
        else check({tag, "_present"}, rd_log.size() - r0, k + 1);
    endtask

    int sd [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 7};
    int sr [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 15};
    int sv [10] = '{1, 3, 6, 10, 15, 21, 28, 28, 29, 36};

    task automatic run_straddle(input string tag, input logic [31:0] base, input int ws);
        stream = '0;
        for (int k = 0; k < 10; k++) put_entry(k, 3, 4, sd[k], sr[k]);
        load_mem();
        snap();
        start_job(base, 16'd10, 4'd3, 4'd4, 8'd0, ws);
        wait_done(tag);
        check({tag, "_pairs"}, got_v.size() - g0, 10);
        for (int k = 0; k < 10; k++) check_pair($sformatf("%s_p%0d", tag, k), k, sv[k], sr[k], (k == 9) ? 1 : 0);
        check({tag, "_reads"}, rd_log.size() - r0, 2);
        check_rd({tag, "_addr0"}, 0, base);
        check_rd({tag, "_addr1"}, 1, base + 32'd1);
        check({tag, "_stable"}, stab_err - s0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(posedge clock);
        #1;
        check("rst_read", sram_read, 0);
        check("rst_addr", sram_address, 0);
        check("rst_valid", w_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        reset = 1'b1;

        // basic decode with latency checks
        stream = '0;
        put_entry(0, 2, 5, 1, 3);
        put_entry(1, 2, 5, 2, 1);
        load_mem();
        snap();
        start_job(32'h0000_0100, 16'd2, 4'd2, 4'd5, 8'd10, 0);
        check("t1_read_rise", sram_read, 1);
        check("t1_addr", sram_address, 32'h100);
        check("t1_busy", busy, 1);
        check("t1_valid_c1", w_valid, 0);
        @(posedge clock); #1;
        check("t1_valid_c2", w_valid, 0);
        @(posedge clock); #1;
        check("t1_valid_c3", w_valid, 1);
        check("t1_first_val", w_value, 11);
        wait_done("t1");
        check("t1_pairs", got_v.size() - g0, 2);
        check_pair("t1_p0", 0, 11, 3, 0);
        check_pair("t1_p1", 1, 13, 1, 1);
        check("t1_reads", rd_log.size() - r0, 1);
        check_rd("t1_rd_addr", 0, 32'h100);

        // straddle with zero wait, then with 3 wait states across the address wrap
        run_straddle("t2", 32'h0000_1000, 0);
        run_straddle("t3", 32'hFFFF_FFFF, 3);
        check("t3_held_cycles", (hold_cnt - h0 >= 6) ? 1 : 0, 1);

        // backpressure with accumulator wrap 250+5=255, 255+3=2
        stream = '0;
        put_entry(0, 4, 3, 5, 2);
        put_entry(1, 4, 3, 3, 7);
        put_entry(2, 4, 3, 1, 0);
        load_mem();
        snap();
        w_ready = 1'b0;
        start_job(32'h0000_0200, 16'd3, 4'd4, 4'd3, 8'd250, 0);
        n = 0;
        while (w_valid !== 1'b1 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        check("bp_valid", w_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", w_valid, 1);
            check("bp_hold_val", w_value, 255);
            check("bp_hold_rep", w_rep, 2);
            check("bp_hold_last", w_last, 0);
            @(posedge clock); #1;
        end
        w_ready = 1'b1;
        wait_done("bp");
        check("bp_pairs", got_v.size() - g0, 3);
        check_pair("bp_p0", 0, 255, 2, 0);
        check_pair("bp_p1", 1, 2, 7, 0);
        check_pair("bp_p2", 2, 3, 0, 1);

        // empty job
        snap();
        start_job(32'h0000_0300, 16'd0, 4'd2, 4'd5, 8'd0, 0);
        check("e0_done_next", done, 1);
        check("e0_cfg_err", cfg_err, 0);
        wait_done("e0");
        check("e0_reads", rd_log.size() - r0, 0);

        // illegal delta_len
        snap();
        start_job(32'h0000_0300, 16'd4, 4'd0, 4'd5, 8'd0, 0);
        check("e1_done_next", done, 1);
        check("e1_cfg_err", cfg_err, 1);
        wait_done("e1");
        check("e1_reads", rd_log.size() - r0, 0);

        // num_len just above its maximum
        snap();
        start_job(32'h0000_0300, 16'd4, 4'd2, 4'd9, 8'd0, 0);
        check("e2_cfg_err", cfg_err, 1);
        wait_done("e2");
        check("e2_reads", rd_log.size() - r0, 0);

        // reset while a read is pending, then a fresh job from another base
        stream = '0;
        put_entry(0, 2, 5, 1, 3);
        put_entry(1, 2, 5, 2, 1);
        load_mem();
        start_job(32'h0000_0040, 16'd2, 4'd2, 4'd5, 8'd10, 5);
        @(posedge clock); #1;
        check("mr_pre_read", sram_read, 1);
        check("mr_pre_addr", sram_address, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        check("mr_read", sram_read, 0);
        check("mr_addr", sram_address, 0);
        check("mr_busy", busy, 0);
        check("mr_valid", w_valid, 0);
        check("mr_value", w_value, 0);
        check("mr_done", done, 0);
        @(posedge clock); #1;
        reset = 1'b1;
        snap();
        start_job(32'h0000_2000, 16'd2, 4'd2, 4'd5, 8'd10, 0);
        wait_done("mr");
        check("mr_pairs", got_v.size() - g0, 2);
        check_pair("mr_p0", 0, 11, 3, 0);
        check_pair("mr_p1", 1, 13, 1, 1);
        check("mr_reads", rd_log.size() - r0, 1);
        check_rd("mr_rd_addr", 0, 32'h2000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
